red_pitaya_enable_sequencer: RTL and testbench

RED_PITAYA_ENABLE_SEQUENCER -- requirements
Module: red_pitaya_enable_sequencer

---
 rtl/red_pitaya_enable_sequencer.sv | 105 ++++++++++
 tb/tb_red_pitaya_enable_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/red_pitaya_enable_sequencer.sv
// Sequences per-channel enables one bit at a time, with a settle window after each change.
// Disables are served highest index first, and always before any pending enable.
module red_pitaya_enable_sequencer #(
    parameter int N      = 4,
    parameter int SETTLE = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_en_i,
    input  logic         kill_i,
    output logic [N-1:0] en_o,
    output logic [N-1:0] up_o,
    output logic         busy_o,
    output logic         chg_o,
    output logic [2:0]   chg_idx_o,
    output logic         state_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t       state, state_n;
    logic [7:0]   cnt, cnt_n;
    logic [N-1:0] tgt, dis, ena;
    logic [N-1:0] en_n, up_n;
    logic         chg_n;
    logic [2:0]   idx_n, dis_idx, ena_idx;

    // chg_idx_o doubles as the index of the channel currently settling.
    always_comb begin
        tgt     = kill_i ? '0 : req_en_i;
        dis     = en_o & ~tgt;
        ena     = tgt & ~en_o;
        busy_o  = (state == ST_SETTLE) || (tgt != en_o);
        dis_idx = '0;
        ena_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (dis[i]) dis_idx = 3'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (ena[i]) ena_idx = 3'(i);
        end

        state_n = state;
        cnt_n   = cnt;
        en_n    = en_o;
        chg_n   = 1'b0;
        idx_n   = chg_idx_o;
        case (state)
            ST_IDLE: begin
                if (|dis) begin
                    for (int i = 0; i < N; i++) begin
                        if (int'(dis_idx) == i) en_n[i] = 1'b0;
                    end
                    idx_n   = dis_idx;
                    chg_n   = 1'b1;
                    cnt_n   = 8'(SETTLE - 1);
                    state_n = ST_SETTLE;
                end else if (|ena) begin
                    for (int i = 0; i < N; i++) begin
                        if (int'(ena_idx) == i) en_n[i] = 1'b1;
                    end
                    idx_n   = ena_idx;
                    chg_n   = 1'b1;
                    cnt_n   = 8'(SETTLE - 1);
                    state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == 8'd0) state_n = ST_IDLE;
                else             cnt_n   = cnt - 8'd1;
            end
            default: state_n = ST_IDLE;
        endcase

        // up_o is computed from next-state values so it lines up with en_o.
        up_n = en_n;
        for (int i = 0; i < N; i++) begin
            if ((state_n == ST_SETTLE) && (int'(idx_n) == i)) up_n[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            en_o      <= '0;
            up_o      <= '0;
            chg_o     <= 1'b0;
            chg_idx_o <= 3'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            en_o      <= en_n;
            up_o      <= up_n;
            chg_o     <= chg_n;
            chg_idx_o <= idx_n;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_red_pitaya_enable_sequencer.sv
// Directed bench for the enable sequencer: three instances cover SETTLE = 8, 4 and 1.
module tb_red_pitaya_enable_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, kill8, busy8, chg8, st8;
    logic [3:0] req8, en8, up8;
    logic [2:0] idx8;
    logic       rst4, kill4, busy4, chg4, st4;
    logic [3:0] req4, en4, up4;
    logic [2:0] idx4;
    logic       rst1, kill1, busy1, chg1, st1;
    logic [3:0] req1, en1, up1;
    logic [2:0] idx1;

    red_pitaya_enable_sequencer #(.N(4), .SETTLE(8)) u8 (
        .clk_i(clk), .rst_i(rst8), .req_en_i(req8), .kill_i(kill8), .en_o(en8), .up_o(up8),
        .busy_o(busy8), .chg_o(chg8), .chg_idx_o(idx8), .state_o(st8));
    red_pitaya_enable_sequencer #(.N(4), .SETTLE(4)) u4 (
        .clk_i(clk), .rst_i(rst4), .req_en_i(req4), .kill_i(kill4), .en_o(en4), .up_o(up4),
        .busy_o(busy4), .chg_o(chg4), .chg_idx_o(idx4), .state_o(st4));
    red_pitaya_enable_sequencer #(.N(4), .SETTLE(1)) u1 (
        .clk_i(clk), .rst_i(rst1), .req_en_i(req1), .kill_i(kill1), .en_o(en1), .up_o(up1),
        .busy_o(busy1), .chg_o(chg1), .chg_idx_o(idx1), .state_o(st1));

    int errors = 0;
    int checks = 0;
    int cur    = 0;
    int pulses = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observation points are negedges; at(k) lands in cycle t0+k.
    task automatic at(input int k);
        repeat (k - cur) @(negedge clk);
        cur = k;
    endtask

    task automatic mark();
        cur = 0;
    endtask

    initial begin
        rst8 = 1'b1; kill8 = 1'b0; req8 = 4'b0000;
        rst4 = 1'b1; kill4 = 1'b0; req4 = 4'b0000;
        rst1 = 1'b1; kill1 = 1'b0; req1 = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_en",   en8,  8'h0);
        chk("rst_up",   up8,  8'h0);
        chk("rst_chg",  chg8, 8'h0);
        chk("rst_idx",  idx8, 8'h0);
        chk("rst_st",   st8,  8'h0);
        chk("rst_busy", busy8, 8'h0);
        rst8 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
        mark();
        at(1);

        // Power-up 0000 -> 1111
        req8 = 4'b1111;
        mark();
        at(1);  chk("pu_en1", en8, 8'h1); chk("pu_chg1", chg8, 8'h1); chk("pu_idx1", idx8, 8'h0);
                chk("pu_up1", up8, 8'h0); chk("pu_busy1", busy8, 8'h1);
        at(2);  chk("pu_chg2", chg8, 8'h0);
        at(9);  chk("pu_en9", en8, 8'h1); chk("pu_up9", up8, 8'h1);
        at(10); chk("pu_en10", en8, 8'h3); chk("pu_idx10", idx8, 8'h1); chk("pu_chg10", chg8, 8'h1);
        at(19); chk("pu_en19", en8, 8'h7); chk("pu_idx19", idx8, 8'h2);
        at(28); chk("pu_en28", en8, 8'hf); chk("pu_idx28", idx8, 8'h3);
        at(35); chk("pu_busy35", busy8, 8'h1);
        at(37); chk("pu_busy37", busy8, 8'h0); chk("pu_up37", up8, 8'hf); chk("pu_idx37", idx8, 8'h3);

        // Kill: descending disables, one per window
        kill8 = 1'b1;
        mark();
        at(1);  chk("kill_en1", en8, 8'h7); chk("kill_up1", up8, 8'h7); chk("kill_idx1", idx8, 8'h3);
        at(10); chk("kill_en10", en8, 8'h3); chk("kill_up10", up8, 8'h3); chk("kill_busy10", busy8, 8'h1);
        at(19); chk("kill_en19", en8, 8'h1); chk("kill_up19", up8, 8'h1); chk("kill_idx19", idx8, 8'h1);
        at(28); chk("kill_en28", en8, 8'h0); chk("kill_up28", up8, 8'h0); chk("kill_idx28", idx8, 8'h0);
        kill8 = 1'b0; req8 = 4'b0011;
        at(29); chk("kill_settle29", en8, 8'h0); chk("kill_busy29", busy8, 8'h1);
        at(37); chk("re_en37", en8, 8'h1); chk("re_idx37", idx8, 8'h0);
        at(46); chk("re_en46", en8, 8'h3); chk("re_idx46", idx8, 8'h1);
        at(56); chk("re_busy56", busy8, 8'h0); chk("re_chg56", chg8, 8'h0);

        // Priority: en=0011, request 1110
        req8 = 4'b1110;
        mark();
        at(1);  chk("pri_en1", en8, 8'h2); chk("pri_idx1", idx8, 8'h0);
        at(9);  chk("pri_en9", en8, 8'h2); chk("pri_up9", up8, 8'h2);
        at(10); chk("pri_en10", en8, 8'h6); chk("pri_idx10", idx8, 8'h2);
        at(19); chk("pri_en19", en8, 8'he); chk("pri_idx19", idx8, 8'h3);
        at(30); chk("pri_busy30", busy8, 8'h0);

        // Clean restart, then reset during the third window
        rst8 = 1'b1; req8 = 4'b0000;
        at(31); chk("clr_en", en8, 8'h0);
        rst8 = 1'b0;
        at(32);
        req8 = 4'b1111;
        mark();
        at(1);  chk("mr_en1", en8, 8'h1);
        at(10); chk("mr_en10", en8, 8'h3);
        at(19); chk("mr_en19", en8, 8'h7);
        at(20); chk("mr_up20", up8, 8'h3);
        at(21);
        rst8 = 1'b1;
        at(22); chk("mr_rst_en", en8, 8'h0); chk("mr_rst_up", up8, 8'h0); chk("mr_rst_chg", chg8, 8'h0);
                chk("mr_rst_idx", idx8, 8'h0); chk("mr_rst_st", st8, 8'h0); chk("mr_rst_busy", busy8, 8'h1);
        rst8 = 1'b0;
        at(23); chk("mr_en23", en8, 8'h1); chk("mr_chg23", chg8, 8'h1); chk("mr_idx23", idx8, 8'h0);
        at(31); chk("mr_en31", en8, 8'h1);
        at(32); chk("mr_en32", en8, 8'h3); chk("mr_idx32", idx8, 8'h1);

        // Revert with SETTLE=4: bit1 requested for two cycles only
        req4 = 4'b0010;
        mark();
        for (int k = 1; k <= 12; k++) begin
            at(k);
            chk("rev_en", en4, (k < 6) ? 8'h2 : 8'h0);
            if (k == 1) begin
                chk("rev_chg1", chg4, 8'h1); chk("rev_idx1", idx4, 8'h1);
            end
            if (k == 2) begin
                chk("rev_chg2", chg4, 8'h0); chk("rev_up2", up4, 8'h0);
                req4 = 4'b0000;
            end
            if (k == 5) chk("rev_up5", up4, 8'h2);
            if (k == 6) begin
                chk("rev_chg6", chg4, 8'h1); chk("rev_idx6", idx4, 8'h1);
            end
        end
        chk("rev_busy12", busy4, 8'h0);

        // SETTLE=1: 0000 -> 0011
        req1 = 4'b0011;
        mark();
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            at(k);
            pulses += int'(chg1);
            chk("s1_en", en1, (k < 3) ? 8'h1 : 8'h3);
            if (k == 3) begin
                chk("s1_chg3", chg1, 8'h1); chk("s1_idx3", idx1, 8'h1);
            end
        end
        chk("s1_pulses", 8'(pulses), 8'd2);
        chk("s1_busy", busy1, 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
